// File: rtl/pixel_pkg.sv
// Shared types and geometry for the paint-canvas frame buffer.
package pixel_pkg;

  localparam int CANVAS_W    = 160;
  localparam int CANVAS_H    = 120;
  localparam int SCALE_SHIFT = 2;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int COLOR_W     = 3;
  localparam int NUM_PIX     = CANVAS_W * CANVAS_H;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [14:0]        addr_t;

  // Write-port request into the RAM
  typedef struct packed {
    logic   en;
    addr_t  addr;
    color_t data;
  } wrReq_t;

  typedef enum logic {CLR_IDLE, CLR_CLEARING} clrState_t;

  // y*160 + x without a multiplier: 160 = 128 + 32
  function automatic addr_t canvasAddr(input logic [7:0] x, input logic [7:0] y);
    addr_t yy;
    yy = addr_t'(y);
    return (yy << 7) + (yy << 5) + addr_t'(x);
  endfunction

endpackage

// File: rtl/pixel_ram.sv
// Simple dual-port colour RAM: one write port, one registered read port.
// Read-first on a same-address collision, the output register has a sync reset.
module pixel_ram
  import pixel_pkg::*;
#(
  parameter int DEPTH = NUM_PIX
) (
  input  logic   clk,
  input  logic   rdRst,
  input  wrReq_t wr,
  input  addr_t  rdAddr,
  output color_t rdData
);

  // Contents start as background (0) at configuration
  color_t mem [DEPTH] = '{default: '0};

  // Write port
  always_ff @(posedge clk) begin
    if (wr.en) mem[wr.addr] <= wr.data;
  end

  // Registered read port; sees the pre-write contents on a collision
  always_ff @(posedge clk) begin
    if (rdRst) rdData <= '0;
    else       rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/pixel_store.sv
// Paint-canvas frame buffer: 160x120 canvas written at canvas coordinates,
// read at 640x480 screen coordinates (each canvas pixel is a 4x4 block).
// Optional macro CLEAR_ON_RESET_EN adds a post-reset clear sweep of the RAM.
module pixel_store
  import pixel_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         brush,
  input  logic [2:0]   newColor,
  input  logic [7:0]   wx,
  input  logic [7:0]   wy,
  input  logic [9:0]   rx,
  input  logic [9:0]   ry,
  output logic [2:0]   colorCode
);

  logic   wrInRange, rdOob, oobQ, clearing;
  addr_t  rdAddr;
  wrReq_t wrReq;
  color_t ramData;

  assign wrInRange = (wx < 8'(CANVAS_W)) && (wy < 8'(CANVAS_H));
  assign rdOob     = (rx >= 10'(SCREEN_W)) || (ry >= 10'(SCREEN_H));
  // OOB reads are steered to address 0 so the RAM index stays in range
  assign rdAddr    = rdOob ? '0 : canvasAddr(8'(rx >> SCALE_SHIFT), 8'(ry >> SCALE_SHIFT));

  // OOB flag travels with the read so it lines up with the RAM data
  always_ff @(posedge clk) begin
    if (reset) oobQ <= 1'b0;
    else       oobQ <= rdOob;
  end

`ifdef CLEAR_ON_RESET_EN
  localparam addr_t LAST_ADDR = addr_t'(NUM_PIX - 1);

  clrState_t state, stateNext;
  addr_t     clrCnt, clrCntNext;

  // Clear engine state; reset always (re)starts the sweep at address 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= CLR_CLEARING;
      clrCnt <= '0;
    end else begin
      state  <= stateNext;
      clrCnt <= clrCntNext;
    end
  end

  // Clear engine next state: one address per cycle until the last entry
  always_comb begin
    stateNext  = state;
    clrCntNext = clrCnt;
    if (state == CLR_CLEARING) begin
      if (clrCnt == LAST_ADDR) begin
        stateNext  = CLR_IDLE;
        clrCntNext = '0;
      end else begin
        clrCntNext = clrCnt + 1'b1;
      end
    end
  end

  assign clearing = (state == CLR_CLEARING);
`else
  assign clearing = 1'b0;
`endif

  // Write-port arbitration: reset blocks, the sweep overrides the brush
  always_comb begin
    wrReq = '{en: 1'b0, addr: '0, data: '0};
    if (!reset) begin
      if (clearing) begin
`ifdef CLEAR_ON_RESET_EN
        wrReq = '{en: 1'b1, addr: clrCnt, data: '0};
`endif
      end else if (brush && wrInRange) begin
        wrReq = '{en: 1'b1, addr: canvasAddr(wx, wy), data: newColor};
      end
    end
  end

  pixel_ram #(.DEPTH(NUM_PIX)) uRam (
    .clk    (clk),
    .rdRst  (reset),
    .wr     (wrReq),
    .rdAddr (rdAddr),
    .rdData (ramData)
  );

  assign colorCode = (oobQ || clearing) ? '0 : ramData;

endmodule

// File: tb/tb_pixel_store.sv
// Directed bench for pixel_store; expectations are hand-derived per vector.
module tb_pixel_store;

  logic       clk = 1'b0;
  logic       reset, brush;
  logic [2:0] newColor;
  logic [7:0] wx, wy;
  logic [9:0] rx, ry;
  logic [2:0] colorCode;

  int nCmp = 0;
  int nErr = 0;

  pixel_store dut (
    .clk       (clk),
    .reset     (reset),
    .brush     (brush),
    .newColor  (newColor),
    .wx        (wx),
    .wy        (wy),
    .rx        (rx),
    .ry        (ry),
    .colorCode (colorCode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  // advance one edge, land 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int x, input int y, input logic [2:0] exp, input string tag);
    rx = 10'(x);
    ry = 10'(y);
    tick();
    chk(tag, colorCode, exp);
  endtask

  task automatic wr(input int x, input int y, input logic [2:0] c);
    wx = 8'(x); wy = 8'(y); newColor = c; brush = 1'b1;
    tick();
    brush = 1'b0;
  endtask

  task automatic waitClear();
`ifdef CLEAR_ON_RESET_EN
    repeat (19210) tick();
`endif
  endtask

  initial begin
    reset = 1'b1; brush = 1'b0; newColor = '0;
    wx = '0; wy = '0; rx = 10'd300; ry = 10'd300;
    tick();
    chk("rst_out", colorCode, 3'b000);
    tick();
    reset = 1'b0;
    waitClear();

    rd(300, 300, 3'b000, "post_rst_rd");

    // 4x4 block of canvas (75,75)
    wr(75, 75, 3'b100);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        rd(300 + i, 300 + j, 3'b100, $sformatf("blk_%0d_%0d", i, j));
    rd(304, 300, 3'b000, "blk_right");
    rd(300, 304, 3'b000, "blk_below");

    // unwritten and out-of-bounds reads
    rd(600, 400, 3'b000, "unwritten");
    wr(0, 0, 3'b111);
    rd(0, 0, 3'b111, "w00");
    rd(640, 0, 3'b000, "oob_x");
    rd(0, 480, 3'b000, "oob_y");
    rd(1023, 1023, 3'b000, "oob_max");
    rd(3, 3, 3'b111, "w00_after_oob");

    // far corner
    wr(159, 119, 3'b110);
    rd(639, 479, 3'b110, "corner_hi");
    rd(636, 476, 3'b110, "corner_lo");
    rd(635, 479, 3'b000, "corner_left");

    // out-of-range writes must not alias
    wr(160, 0, 3'b011);
    wr(0, 120, 3'b011);
    wr(255, 255, 3'b011);
    rd(0, 4, 3'b000, "alias_c01");
    rd(0, 0, 3'b111, "alias_c00");
    for (int x = 1; x < 160; x++)
      rd(x * 4, 0, 3'b000, $sformatf("row0_%0d", x));

    // read-first collision
    wr(10, 10, 3'b101);
    wx = 8'd10; wy = 8'd10; newColor = 3'b011; brush = 1'b1;
    rx = 10'd40; ry = 10'd40;
    tick();
    brush = 1'b0;
    chk("rf_old", colorCode, 3'b101);
    tick();
    chk("rf_new", colorCode, 3'b011);

    // reset mid-stream
    rd(300, 300, 3'b100, "pre_rst");
    reset = 1'b1;
    tick();
    chk("mid_rst", colorCode, 3'b000);
    reset = 1'b0;
    tick();
`ifdef CLEAR_ON_RESET_EN
    chk("rst_resume", colorCode, 3'b000);
    repeat (100) tick();
    wr(0, 0, 3'b010);
    rd(0, 0, 3'b000, "sweep_forced0");
    waitClear();
    rd(300, 300, 3'b000, "cleared_7575");
    rd(0, 0, 3'b000, "sweep_wr_drop");
    rd(40, 40, 3'b000, "cleared_1010");
    wr(1, 1, 3'b001);
    rd(4, 4, 3'b001, "wr_after_sweep");
`else
    chk("rst_resume", colorCode, 3'b100);
    rd(0, 0, 3'b111, "persist_00");
    rd(40, 40, 3'b011, "persist_1010");
    // writes are accepted right after release
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wr(1, 1, 3'b001);
    rd(4, 4, 3'b001, "wr_after_rst");
    // writes are blocked while reset is high
    reset = 1'b1;
    wr(2, 2, 3'b110);
    reset = 1'b0;
    rd(8, 8, 3'b000, "wr_blocked_rst");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/pixel_store.md
Name: pixel_store

Overview:
- Frame-buffer block for the paint canvas.
- Stores one 3-bit colour code per canvas pixel on a 160x120 low-resolution grid.
- Written by the brush logic at canvas coordinates; read by the VGA pipeline at 640x480 screen coordinates, each canvas pixel covering a 4x4 screen block.
- Sits between the brush/cursor controller (write side) and the VGA colour decoder (read side).

Parameters:
- CANVAS_W, 160, canvas width in canvas pixels.
- CANVAS_H, 120, canvas height in canvas pixels.
- SCALE_SHIFT, 2, log2 of the screen-to-canvas scale factor (4x).
- COLOR_W, 3, colour code width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- brush  input  1  write enable; paint newColor at (wx,wy) this cycle.
- newColor  input  3  colour code to write.
- wx  input  8  write canvas x, valid 0..159.
- wy  input  8  write canvas y, valid 0..119.
- rx  input  10  read screen x, valid 0..639.
- ry  input  10  read screen y, valid 0..479.
- colorCode  output  3  colour at (rx,ry), registered.

Behaviour:
- Storage: CANVAS_W*CANVAS_H = 19200 entries x COLOR_W bits, single array inferable as one simple-dual-port block RAM.
- All entries are initialised to 0 (background) at configuration.
- Write address = wy*160 + wx, computed as (wy<<7)+(wy<<5)+wx.
- Write occurs on the clk edge when brush=1 and reset=0 and wx<160 and wy<120.
- Out-of-range write coordinates are ignored; no aliasing or wrap.
- Read: cx = rx>>2, cy = ry>>2, address = cy*160 + cx.
- colorCode is valid exactly 1 cycle after rx/ry are presented (registered RAM output).
- The read is out of bounds when rx>=640 or ry>=480. The OOB flag is registered alongside the read so it aligns with the data; an OOB read produces colorCode=0.
- Read and write of the same address in the same cycle is read-first: colorCode shows the old value, and the new value is visible on a read issued the next cycle or later.
- Reset: colorCode and the OOB flag register go to 0 in the cycle reset is sampled high. Writes are blocked while reset=1. Memory contents are NOT cleared unless CLEAR_ON_RESET_EN is defined.
- Reset asserted mid-operation: colorCode is 0 for the cycle following each high-reset sample. Normal reads resume 1 cycle after reset is released.
- No handshake; read and write ports operate independently every cycle.

Optional Feature:
- Macro: CLEAR_ON_RESET_EN.
- When defined, a clear engine runs after reset deasserts and sweeps addresses 0..19199, writing 0 at one address per cycle (19200 cycles).
- The clear engine has two states: IDLE and CLEARING. Reset forces CLEARING with the counter at 0; the engine returns to IDLE after address 19199 is written.
- During CLEARING, brush writes are ignored and colorCode is forced to 0.
- A reset asserted during CLEARING restarts the sweep from address 0.
- When not defined: no clear engine; contents persist across reset; writes are accepted in the first cycle after reset deasserts.

Decomposition:
- Shared package pixel_pkg: CANVAS_W, CANVAS_H, SCALE_SHIFT, SCREEN_W=640, SCREEN_H=480, COLOR_W, typedef color_t (logic [2:0]), typedef addr_t (15-bit), and a function computing the canvas address from (x,y).
- One natural sub-module, pixel_ram: simple dual-port RAM with a registered read port and a write-enable port.
- pixel_store itself holds the address arithmetic, bounds checks, OOB pipeline register and the optional clear engine.

Test Plan:
- After reset, read rx=300, ry=300 -> colorCode=000 one cycle later.
- Write brush=1, newColor=100, wx=75, wy=75 for one cycle, then read rx=300..303, ry=300..303 -> colorCode=100 at all 16 positions; rx=304, ry=300 -> 000.
- Read rx=600, ry=400 (in bounds, unwritten) -> 000. Read rx=640, ry=0 and rx=0, ry=480 -> 000 even after writing 111 at wx=0, wy=0.
- Write wx=160, wy=0, newColor=011 -> reads of canvas (0,1) and all row 0 are unchanged; no aliasing.
- Same-cycle write 011 at wx=10, wy=10 with read rx=40, ry=40 -> colorCode shows the previous value; the next cycle's read returns 011.
- Assert reset for one cycle mid-stream -> colorCode=0 next cycle. Without CLEAR_ON_RESET_EN, previously written 100 at (75,75) is still read back afterwards. With CLEAR_ON_RESET_EN it reads 000, and a write issued during the sweep does not stick.
